// File: rtl/menu_text_ctl.sv
// Menu text-box controller: maps the VGA raster onto a 16x16-cell text ROM
// address and runs the menu cursor / confirm / active state machine.
module menu_text_ctl #(
   parameter int unsigned X0    = 256,
   parameter int unsigned Y0    = 192,
   parameter int unsigned ITEMS = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] hcount,
   input  logic [10:0] vcount,
   input  logic        vblnk,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_enter,
   input  logic        btn_back,
   output logic [7:0]  char_xy,
   output logic [3:0]  char_line,
   output logic        text_en,
   output logic [1:0]  page_sel,
   output logic        highlight,
   output logic [1:0]  menu_item,
   output logic        item_valid
);

   typedef enum logic [1:0] {MENU, CONFIRM, ACTIVE} state_e;
   typedef enum logic [1:0] {MV_NONE, MV_UP, MV_DN} move_e;

   localparam logic [11:0] X0_W = 12'(X0);
   localparam logic [11:0] Y0_W = 12'(Y0);
   localparam logic [1:0]  LAST = 2'(ITEMS - 1);

   state_e      state_q, state_d;
   move_e       move_q, move_d, mv;
   logic [1:0]  menu_item_q, menu_item_d;
   logic [3:0]  conf_cnt_q, conf_cnt_d;
   logic        item_valid_q, item_valid_d;
   logic [4:0]  frame_cnt_q;
   logic [3:0]  btn_q;
   logic        vblnk_q;

   logic        text_en_q, text_en_d;
   logic [7:0]  char_xy_q, char_xy_d;
   logic [3:0]  char_line_q, char_line_d;
   logic        highlight_q, highlight_d;

   logic [11:0] hx, vy, dx, dy;
   logic        in_box;
   logic [3:0]  hl_row;
   logic [3:0]  btn_now, press;
   logic        p_up, p_dn, p_enter, p_back, vb_rise;

   assign hx      = {1'b0, hcount};
   assign vy      = {1'b0, vcount};
   assign dx      = hx - X0_W;
   assign dy      = vy - Y0_W;
   assign in_box  = (hx >= X0_W) && (dx < 12'd128) && (vy >= Y0_W) && (dy < 12'd256);
   assign hl_row  = 4'd3 + {1'b0, menu_item_q, 1'b0};

   assign btn_now = {btn_back, btn_enter, btn_down, btn_up};
   assign press   = btn_now & ~btn_q;
   assign p_up    = press[0];
   assign p_dn    = press[1];
   assign p_enter = press[2];
   assign p_back  = press[3];
   assign vb_rise = vblnk & ~vblnk_q;

   // Next values for the registered text-box address and highlight.
   always_comb begin
      text_en_d   = in_box;
      char_xy_d   = '0;
      char_line_d = '0;
      highlight_d = 1'b0;
      if (in_box) begin
         char_xy_d   = {dy[7:4], dx[6:3]};
         char_line_d = dy[3:0];
         if (dy[7:4] == hl_row) begin
            highlight_d = (state_q == MENU) ||
                          ((state_q == CONFIRM) && frame_cnt_q[2]);
         end
      end
   end

   // Video pipeline registers: one cycle from raster position to outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         text_en_q   <= 1'b0;
         char_xy_q   <= '0;
         char_line_q <= '0;
         highlight_q <= 1'b0;
      end else begin
         text_en_q   <= text_en_d;
         char_xy_q   <= char_xy_d;
         char_line_q <= char_line_d;
         highlight_q <= highlight_d;
      end
   end

   // Menu FSM next-state, cursor movement and confirm countdown.
   always_comb begin
      state_d      = state_q;
      move_d       = move_q;
      menu_item_d  = menu_item_q;
      conf_cnt_d   = conf_cnt_q;
      item_valid_d = 1'b0;
      mv           = move_q;
      case (state_q)
         MENU: begin
            if (p_enter) begin
               state_d    = CONFIRM;
               move_d     = MV_NONE;
               conf_cnt_d = '0;
            end else begin
               // A fresh press this cycle overrides whatever was pending.
               if (p_up && !p_dn)      mv = MV_UP;
               else if (p_dn && !p_up) mv = MV_DN;
               if (vb_rise) begin
                  move_d = MV_NONE;
                  if (mv == MV_UP)
                     menu_item_d = (menu_item_q == 2'd0) ? LAST : menu_item_q - 2'd1;
                  else if (mv == MV_DN)
                     menu_item_d = (menu_item_q == LAST) ? 2'd0 : menu_item_q + 2'd1;
               end else begin
                  move_d = mv;
               end
            end
         end
         CONFIRM: begin
            if (p_back) begin
               state_d = MENU;
               move_d  = MV_NONE;
            end else if (vb_rise) begin
               if (conf_cnt_q == 4'd15) begin
                  state_d      = ACTIVE;
                  item_valid_d = 1'b1;
               end else begin
                  conf_cnt_d = conf_cnt_q + 4'd1;
               end
            end
         end
         ACTIVE: begin
            if (p_back) begin
               state_d = MENU;
               move_d  = MV_NONE;
            end
         end
         default: begin
            state_d = MENU;
            move_d  = MV_NONE;
         end
      endcase
   end

   // Control state registers, button/vblank edge history and frame counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= MENU;
         move_q       <= MV_NONE;
         menu_item_q  <= '0;
         conf_cnt_q   <= '0;
         item_valid_q <= 1'b0;
         frame_cnt_q  <= '0;
         btn_q        <= '0;
         vblnk_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         move_q       <= move_d;
         menu_item_q  <= menu_item_d;
         conf_cnt_q   <= conf_cnt_d;
         item_valid_q <= item_valid_d;
         btn_q        <= btn_now;
         vblnk_q      <= vblnk;
         if (vb_rise) frame_cnt_q <= frame_cnt_q + 5'd1;
      end
   end

   assign char_xy    = char_xy_q;
   assign char_line  = char_line_q;
   assign text_en    = text_en_q;
   assign highlight  = highlight_q;
   assign menu_item  = menu_item_q;
   assign item_valid = item_valid_q;
   assign page_sel   = (state_q == ACTIVE) ? menu_item_q + 2'd1 : 2'd0;

endmodule

// File: tb/tb_menu_text_ctl.sv
// Directed bench for menu_text_ctl with default parameters (X0=256, Y0=192, ITEMS=3).
module tb_menu_text_ctl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] hcount, vcount;
   logic        vblnk, btn_up, btn_down, btn_enter, btn_back;
   logic [7:0]  char_xy;
   logic [3:0]  char_line;
   logic        text_en, highlight, item_valid;
   logic [1:0]  page_sel, menu_item;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   int unsigned fc     = 0;
   int unsigned iv_cnt = 0;

   menu_text_ctl #(.X0(256), .Y0(192), .ITEMS(3)) dut (
      .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .vblnk(vblnk),
      .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter), .btn_back(btn_back),
      .char_xy(char_xy), .char_line(char_line), .text_en(text_en), .page_sel(page_sel),
      .highlight(highlight), .menu_item(menu_item), .item_valid(item_valid)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic vpulse();
      vblnk = 1'b1;
      tick();
      vblnk = 1'b0;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; hcount = '0; vcount = '0; vblnk = 1'b0;
      btn_up = 1'b0; btn_down = 1'b0; btn_enter = 1'b0; btn_back = 1'b0;
      tick(); tick();
      check_eq("rst char_xy", char_xy, 0);
      check_eq("rst text_en", text_en, 0);
      check_eq("rst menu_item", menu_item, 0);
      check_eq("rst page_sel", page_sel, 0);
      check_eq("rst item_valid", item_valid, 0);
      rst_n = 1'b1;
      tick();

      // Address mapping
      hcount = 11'd273; vcount = 11'd229;
      tick();
      check_eq("map char_xy", char_xy, 8'h22);
      check_eq("map char_line", char_line, 5);
      check_eq("map text_en", text_en, 1);
      check_eq("map highlight row2", highlight, 0);
      hcount = 11'd384;
      tick();
      check_eq("right edge text_en", text_en, 0);
      check_eq("right edge char_xy", char_xy, 0);
      check_eq("right edge char_line", char_line, 0);
      hcount = 11'd255; vcount = 11'd200;
      tick();
      check_eq("left edge text_en", text_en, 0);
      hcount = 11'd383; vcount = 11'd447;
      tick();
      check_eq("corner char_xy", char_xy, 8'hff);
      check_eq("corner char_line", char_line, 15);
      check_eq("corner text_en", text_en, 1);
      vcount = 11'd448;
      tick();
      check_eq("bottom edge text_en", text_en, 0);

      // Up from 0 wraps to 2, applied only at vblank rise
      btn_up = 1'b1; tick(); btn_up = 1'b0; tick();
      check_eq("up pending item", menu_item, 0);
      vblnk = 1'b1; tick(); fc++;
      check_eq("up applied item", menu_item, 2);
      vblnk = 1'b0; tick();
      hcount = 11'd264; vcount = 11'd307;
      tick();
      check_eq("row7 highlight", highlight, 1);
      vcount = 11'd240;
      tick();
      check_eq("row3 no highlight", highlight, 0);

      // Held down button counts once; down from 2 wraps to 0
      btn_down = 1'b1; tick();
      vpulse(); fc++;
      check_eq("down wrap item", menu_item, 0);
      vpulse(); fc++;
      check_eq("down held item", menu_item, 0);
      btn_down = 1'b0; tick();

      // Up and down together cancel
      btn_up = 1'b1; btn_down = 1'b1; tick();
      btn_up = 1'b0; btn_down = 1'b0; tick();
      vpulse(); fc++;
      check_eq("up+down item", menu_item, 0);

      // Newer pending move overwrites older
      btn_up = 1'b1; tick(); btn_up = 1'b0; tick();
      btn_down = 1'b1; tick(); btn_down = 1'b0; tick();
      vpulse(); fc++;
      check_eq("overwrite item", menu_item, 1);

      // Enter + down together: enter wins
      hcount = 11'd264; vcount = 11'd272;
      btn_enter = 1'b1; btn_down = 1'b1; tick();
      btn_enter = 1'b0; btn_down = 1'b0; tick();
      check_eq("confirm item", menu_item, 1);
      check_eq("confirm page_sel", page_sel, 0);
      check_eq("confirm blink fc5", highlight, (fc >> 2) & 1);
      for (int k = 1; k <= 15; k++) begin
         vblnk = 1'b1; tick(); fc++;
         check_eq($sformatf("confirm valid %0d", k), item_valid, 0);
         vblnk = 1'b0; tick();
         check_eq($sformatf("confirm blink %0d", k), highlight, (fc >> 2) & 1);
      end
      vblnk = 1'b1; tick(); fc++;
      check_eq("commit item_valid", item_valid, 1);
      check_eq("commit menu_item", menu_item, 1);
      check_eq("commit page_sel", page_sel, 2);
      vblnk = 1'b0; tick();
      check_eq("commit pulse width", item_valid, 0);
      check_eq("active highlight", highlight, 0);
      check_eq("active page_sel", page_sel, 2);

      // Up ignored in ACTIVE
      btn_up = 1'b1; tick(); btn_up = 1'b0; tick();
      vpulse(); fc++;
      check_eq("active ignore up", menu_item, 1);
      check_eq("active ignore page", page_sel, 2);

      // Back returns to MENU keeping cursor
      btn_back = 1'b1; tick();
      check_eq("back page_sel", page_sel, 0);
      check_eq("back menu_item", menu_item, 1);
      btn_back = 1'b0; tick();
      check_eq("back row5 highlight", highlight, 1);

      // Reset asserted mid-CONFIRM
      btn_enter = 1'b1; tick(); btn_enter = 1'b0; tick();
      for (int k = 0; k < 5; k++) vpulse();
      check_eq("pre-reset text_en", text_en, 1);
      rst_n = 1'b0;
      #1;
      check_eq("mid rst char_xy", char_xy, 0);
      check_eq("mid rst char_line", char_line, 0);
      check_eq("mid rst text_en", text_en, 0);
      check_eq("mid rst highlight", highlight, 0);
      check_eq("mid rst menu_item", menu_item, 0);
      check_eq("mid rst page_sel", page_sel, 0);
      check_eq("mid rst item_valid", item_valid, 0);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         vblnk = 1'b1; tick();
         if (item_valid) iv_cnt++;
         vblnk = 1'b0; tick();
         if (item_valid) iv_cnt++;
      end
      check_eq("no valid after reset", iv_cnt, 0);
      check_eq("post rst page_sel", page_sel, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
